// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: FSM states, trigger sources and edges.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } acq_state_t;

    typedef enum logic [1:0] {
        TRIG_SRC_CHA   = 2'd0,
        TRIG_SRC_CHB   = 2'd1,
        TRIG_SRC_EXT   = 2'd2,
        TRIG_SRC_FORCE = 2'd3
    } trig_src_t;

    localparam logic TRIG_EDGE_RISE = 1'b1;
    localparam logic TRIG_EDGE_FALL = 1'b0;

endpackage

// File: rtl/acq_sequencer_if.sv
// Sample RAM write port driven by the acquisition sequencer.
interface acq_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  buf_we;
    logic [ADDR_WIDTH-1:0] buf_waddr;

    modport master (output buf_we, buf_waddr);
    modport slave  (input  buf_we, buf_waddr);
endinterface

// File: rtl/acq_trig_detect.sv
// Trigger detection: remembers the previous decimated sample and ext_trig level,
// evaluates the latched trigger condition on each tick while armed.
module acq_trig_detect
    import acq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  tick,
    input  logic                  armed,
    input  logic [DATA_WIDTH-1:0] adc_cha,
    input  logic [DATA_WIDTH-1:0] adc_chb,
    input  logic                  ext_trig,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic                  trig_edge,
    input  trig_src_t             trig_source,
    output logic                  trig_hit
);

    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_ext;
    logic                  prev_valid;
    logic                  first_armed;
    logic                  level_hit;
    logic                  hit;

    assign cur = (trig_source == TRIG_SRC_CHB) ? adc_chb : adc_cha;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev        <= '0;
            prev_ext    <= 1'b0;
            prev_valid  <= 1'b0;
            first_armed <= 1'b0;
        end else if (clear) begin
            prev_valid  <= 1'b0;
            first_armed <= 1'b1;
        end else if (tick) begin
            prev       <= cur;
            prev_ext   <= ext_trig;
            prev_valid <= 1'b1;
            if (armed) first_armed <= 1'b0;
        end
    end

    always_comb begin
        level_hit = 1'b0;
        hit       = 1'b0;
        if (trig_edge == TRIG_EDGE_RISE) level_hit = (prev < trig_value) && (cur >= trig_value);
        else                             level_hit = (prev > trig_value) && (cur <= trig_value);
        unique case (trig_source)
            TRIG_SRC_CHA,
            TRIG_SRC_CHB:   hit = prev_valid && level_hit;
            TRIG_SRC_EXT:   hit = prev_valid && ext_trig && !prev_ext;
            TRIG_SRC_FORCE: hit = first_armed;
            default:        hit = 1'b0;
        endcase
        trig_hit = tick && armed && hit;
    end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: decimates the ADC stream, fills the circular pre-trigger window,
// waits for the trigger, then writes the post-trigger window into the sample RAM.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] num_samples,
    input  logic [ADDR_WIDTH-1:0] pre_trigger,
    input  logic [DEC_WIDTH-1:0]  decimation_factor,
    input  logic [DATA_WIDTH-1:0] trigger_value,
    input  logic                  trigger_edge,
    input  logic [1:0]            trigger_source,
    input  logic [DATA_WIDTH-1:0] adc_cha,
    input  logic [DATA_WIDTH-1:0] adc_chb,
    input  logic                  adc_valid,
    input  logic                  ext_trig,
    acq_sequencer_if.master       buf_bus,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done
);

    acq_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] num_m1, pre_lat, num_m1_in, pre_in;
    logic [ADDR_WIDTH-1:0] wr_ptr, pre_cnt, post_rem, post_len;
    logic [DEC_WIDTH-1:0]  dec_m1, dec_cnt;
    logic [DATA_WIDTH-1:0] tv_lat;
    logic                  edge_lat;
    trig_src_t             src_lat;
    logic                  buf_we_q;
    logic [ADDR_WIDTH-1:0] buf_waddr_q;
    logic                  tick, cap, armed, cap_tick, wr_tick, start_go, trig_hit;

    // Clamped config is stored as "minus one" so wrap and reload compares need no subtract.
    assign num_m1_in = (num_samples == '0) ? '0 : num_samples - 1'b1;
    assign pre_in    = (pre_trigger > num_m1_in) ? num_m1_in : pre_trigger;
    assign post_len  = num_m1 - pre_lat;

    assign start_go = start && !stop && (state == ST_IDLE);
    assign armed    = (state == ST_ARMED);
    assign cap      = (state == ST_PRE) || armed || (state == ST_POST);
    assign tick     = adc_valid && (dec_cnt == '0);
    assign cap_tick = tick && cap;
    assign wr_tick  = cap_tick && !stop;

    assign busy              = cap;
    assign done              = (state == ST_DONE);
    assign buf_bus.buf_we    = buf_we_q;
    assign buf_bus.buf_waddr = buf_waddr_q;

    acq_trig_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_go),
        .tick        (cap_tick),
        .armed       (armed),
        .adc_cha     (adc_cha),
        .adc_chb     (adc_chb),
        .ext_trig    (ext_trig),
        .trig_value  (tv_lat),
        .trig_edge   (edge_lat),
        .trig_source (src_lat),
        .trig_hit    (trig_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = (pre_in == '0) ? ST_ARMED : ST_PRE;
            ST_PRE:   if (cap_tick && (pre_cnt == pre_lat - 1'b1)) state_nxt = ST_ARMED;
            ST_ARMED: if (trig_hit) state_nxt = (post_len == '0) ? ST_DONE : ST_POST;
            ST_POST:  if (cap_tick && (post_rem == ADDR_WIDTH'(1))) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (stop) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_m1      <= '0;
            pre_lat     <= '0;
            dec_m1      <= '0;
            tv_lat      <= '0;
            edge_lat    <= 1'b0;
            src_lat     <= TRIG_SRC_CHA;
            dec_cnt     <= '0;
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            post_rem    <= '0;
            trig_addr   <= '0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
        end else begin
            if (start_go) begin
                num_m1   <= num_m1_in;
                pre_lat  <= pre_in;
                dec_m1   <= (decimation_factor == '0) ? '0 : decimation_factor - 1'b1;
                tv_lat   <= trigger_value;
                edge_lat <= trigger_edge;
                src_lat  <= trig_src_t'(trigger_source);
            end

            if (start_go)       dec_cnt <= '0;
            else if (tick)      dec_cnt <= dec_m1;
            else if (adc_valid) dec_cnt <= dec_cnt - 1'b1;

            buf_we_q <= wr_tick;
            if (wr_tick) begin
                buf_waddr_q <= wr_ptr;
                wr_ptr      <= (wr_ptr == num_m1) ? '0 : wr_ptr + 1'b1;
            end else if (state == ST_IDLE) begin
                wr_ptr <= '0;
            end

            if (state == ST_IDLE)                   pre_cnt <= '0;
            else if (wr_tick && state == ST_PRE)    pre_cnt <= pre_cnt + 1'b1;

            if (trig_hit && !stop) begin
                trig_addr <= wr_ptr;
                post_rem  <= post_len;
            end else if (wr_tick && state == ST_POST) begin
                post_rem <= post_rem - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: directed captures plus randomized ones,
// checked against a tick-level reference model of the acquisition rules.
module tb_acq_sequencer;
    import acq_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int DECW = 32;
    localparam int LMAX = 160;

    logic            clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
    logic [AW-1:0]   num_samples = '0, pre_trigger = '0;
    logic [DECW-1:0] decimation_factor = '0;
    logic [DW-1:0]   trigger_value = '0, adc_cha = '0, adc_chb = '0;
    logic            trigger_edge = 1'b0, adc_valid = 1'b0, ext_trig = 1'b0;
    logic [1:0]      trigger_source = '0;
    logic [AW-1:0]   trig_addr;
    logic            busy, done;

    acq_sequencer_if #(.ADDR_WIDTH(AW)) buf_bus ();

    acq_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEC_WIDTH(DECW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .stop              (stop),
        .num_samples       (num_samples),
        .pre_trigger       (pre_trigger),
        .decimation_factor (decimation_factor),
        .trigger_value     (trigger_value),
        .trigger_edge      (trigger_edge),
        .trigger_source    (trigger_source),
        .adc_cha           (adc_cha),
        .adc_chb           (adc_chb),
        .adc_valid         (adc_valid),
        .ext_trig          (ext_trig),
        .buf_bus           (buf_bus),
        .trig_addr         (trig_addr),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, failures = 0;
    int wq_addr[$], wq_cyc[$];
    int done_cnt = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (buf_bus.buf_we) begin
            wq_addr.push_back(int'(buf_bus.buf_waddr));
            wq_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Stimulus tables and latched scenario configuration
    logic          v_a[LMAX];
    logic [DW-1:0] a_a[LMAX], b_a[LMAX];
    logic          e_a[LMAX];
    int            len, start_at;
    int            c_num, c_pre, c_dec, c_tv, c_edge, c_src;

    int ex_addr[$], ex_cyc[$];
    int ex_fin, ex_trig, ex_done_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks the decimated sample stream tick by tick: writes go to consecutive ring slots,
    // the first `pre` ticks only fill the window, later ticks test the trigger rule.
    task automatic model(input int base);
        int n, num, pre, w, vcount, post_left, prev, cur;
        bit trig_d, have_prev, pext, hit;
        n    = (c_dec == 0) ? 1 : c_dec;
        num  = (c_num == 0) ? 1 : c_num;
        pre  = (c_pre > num - 1) ? num - 1 : c_pre;
        ex_addr.delete(); ex_cyc.delete();
        ex_fin = 0; ex_trig = 0; ex_done_cyc = 0;
        w = 0; vcount = 0; post_left = 0; prev = 0; cur = 0;
        trig_d = 0; have_prev = 0; pext = 0; hit = 0;
        for (int c = 0; c < len; c++) begin
            if (!v_a[c]) continue;
            vcount++;
            if ((vcount - 1) % n != 0) continue;
            if (ex_fin != 0) continue;
            cur = (c_src == 1) ? int'(b_a[c]) : int'(a_a[c]);
            ex_addr.push_back(w % num);
            ex_cyc.push_back(base + c + 1);
            w++;
            if (!trig_d) begin
                if (w - 1 >= pre) begin
                    case (c_src)
                        0, 1:    hit = have_prev && ((c_edge != 0) ? (prev < c_tv && cur >= c_tv)
                                                                   : (prev > c_tv && cur <= c_tv));
                        2:       hit = have_prev && e_a[c] && !pext;
                        default: hit = (w - 1 == pre);
                    endcase
                    if (hit) begin
                        trig_d    = 1;
                        ex_trig   = (w - 1) % num;
                        post_left = num - pre - 1;
                        if (post_left == 0) begin ex_fin = 1; ex_done_cyc = base + c + 1; end
                    end
                end
            end else begin
                post_left--;
                if (post_left == 0) begin ex_fin = 1; ex_done_cyc = base + c + 1; end
            end
            prev = cur; pext = e_a[c]; have_prev = 1;
        end
    endtask

    task automatic run_capture(input string tag);
        int base, nw;
        num_samples       = AW'(c_num);
        pre_trigger       = AW'(c_pre);
        decimation_factor = DECW'(c_dec);
        trigger_value     = DW'(c_tv);
        trigger_edge      = c_edge[0];
        trigger_source    = 2'(c_src);
        adc_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base = cyc;
        wq_addr.delete(); wq_cyc.delete(); done_cnt = 0;
        chk({tag, "_busy_start"}, 64'(busy), 64'(1));
        num_samples       = AW'($urandom);
        pre_trigger       = AW'($urandom);
        decimation_factor = DECW'($urandom);
        trigger_value     = DW'($urandom);
        trigger_edge      = 1'($urandom);
        trigger_source    = 2'($urandom);
        model(base);
        for (int c = 0; c < len; c++) begin
            adc_valid = v_a[c]; adc_cha = a_a[c]; adc_chb = b_a[c]; ext_trig = e_a[c];
            start = (c == start_at);
            @(posedge clk); #1;
        end
        adc_valid = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (ex_fin == 0) begin
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
        end
        chk({tag, "_busy_end"}, 64'(busy), 64'(0));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(ex_fin));
        if (ex_fin != 0) begin
            chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(ex_done_cyc));
            chk({tag, "_trig_addr"}, 64'(trig_addr), 64'(ex_trig));
        end
        chk({tag, "_nwrites"}, 64'(wq_addr.size()), 64'(ex_addr.size()));
        nw = (wq_addr.size() < ex_addr.size()) ? wq_addr.size() : ex_addr.size();
        for (int i = 0; i < nw; i++) begin
            chk({tag, "_waddr"}, 64'(wq_addr[i]), 64'(ex_addr[i]));
            chk({tag, "_wcyc"},  64'(wq_cyc[i]),  64'(ex_cyc[i]));
        end
    endtask

    task automatic clear_tables();
        for (int c = 0; c < LMAX; c++) begin
            v_a[c] = 1'b0; a_a[c] = '0; b_a[c] = '0; e_a[c] = 1'b0;
        end
        start_at = -1;
    endtask

    initial begin
        #1;
        chk("reset_busy",  64'(busy), 64'(0));
        chk("reset_done",  64'(done), 64'(0));
        chk("reset_we",    64'(buf_bus.buf_we), 64'(0));
        chk("reset_waddr", 64'(buf_bus.buf_waddr), 64'(0));
        chk("reset_taddr", 64'(trig_addr), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Ramp on CHA rising through 0x80; a start while busy must be ignored
        clear_tables(); len = 40; start_at = 1;
        for (int c = 0; c < len; c++) begin
            v_a[c] = 1'b1; a_a[c] = DW'(8 * c); b_a[c] = DW'($urandom);
        end
        c_num = 16; c_pre = 4; c_dec = 1; c_tv = 'h80; c_edge = 1; c_src = 0;
        run_capture("ramp_cha");

        // Decimation by 3 and decimation 0 treated as 1, with forced trigger
        clear_tables(); len = 40;
        for (int c = 0; c < len; c++) v_a[c] = 1'b1;
        c_num = 8; c_pre = 2; c_dec = 3; c_tv = 0; c_edge = 1; c_src = 3;
        run_capture("dec3");
        c_dec = 0;
        run_capture("dec0");

        // No pre-trigger window: forced trigger on the first tick
        clear_tables(); len = 30;
        for (int c = 0; c < len; c++) v_a[c] = 1'b1;
        c_num = 16; c_pre = 0; c_dec = 1; c_tv = 0; c_edge = 1; c_src = 3;
        run_capture("pre0_force");

        // pre = num-1: ring wraps many times, done right after the trigger
        clear_tables(); len = 80;
        for (int c = 0; c < len; c++) begin
            v_a[c] = 1'b1; a_a[c] = (c < 55) ? DW'('h10) : DW'('h90);
        end
        c_num = 16; c_pre = 15; c_dec = 1; c_tv = 'h80; c_edge = 1; c_src = 0;
        run_capture("wrap_pre15");

        // Stop in POST: IDLE next cycle, no more writes, no done
        clear_tables();
        num_samples = 16; pre_trigger = 0; decimation_factor = 1; trigger_source = 2'd3;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        adc_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wq_addr.delete(); wq_cyc.delete(); done_cnt = 0;
        chk("stop_busy", 64'(busy), 64'(0));
        repeat (20) @(posedge clk);
        #1 adc_valid = 1'b0;
        chk("stop_nwrites", 64'(wq_addr.size()), 64'(0));
        chk("stop_done", 64'(done_cnt), 64'(0));
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        chk("stop_over_start", 64'(busy), 64'(0));

        // Falling edge on CHB at 0x40; touching 0x40 then falling below must not fire
        clear_tables(); len = 20;
        begin
            logic [DW-1:0] seq [5];
            seq = '{8'h30, 8'h40, 8'h30, 8'h50, 8'h40};
            for (int c = 0; c < len; c++) begin
                v_a[c] = 1'b1; a_a[c] = DW'($urandom);
                b_a[c] = (c < 5) ? seq[c] : DW'('h20);
            end
        end
        c_num = 8; c_pre = 0; c_dec = 1; c_tv = 'h40; c_edge = 0; c_src = 1;
        run_capture("fall_chb");

        // Randomized captures
        for (int r = 0; r < 8; r++) begin
            clear_tables(); len = 120;
            for (int c = 0; c < len; c++) begin
                v_a[c] = ($urandom_range(0, 9) < 7);
                a_a[c] = DW'($urandom); b_a[c] = DW'($urandom);
                e_a[c] = 1'($urandom);
            end
            c_num = $urandom_range(0, 20); c_pre = $urandom_range(0, 24);
            c_dec = $urandom_range(0, 3);  c_tv = $urandom_range(0, 255);
            c_edge = $urandom_range(0, 1); c_src = $urandom_range(0, 3);
            run_capture("random");
        end

        // Asynchronous reset while ARMED clears every output immediately
        clear_tables();
        num_samples = 16; pre_trigger = 0; decimation_factor = 1;
        trigger_value = 8'hFF; trigger_edge = 1'b1; trigger_source = 2'd0; adc_cha = '0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        adc_valid = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_busy", 64'(busy), 64'(1));
        chk("pre_rst_we",   64'(buf_bus.buf_we), 64'(1));
        rst = 1'b0;
        #1;
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_we",    64'(buf_bus.buf_we), 64'(0));
        chk("rst_done",  64'(done), 64'(0));
        chk("rst_waddr", 64'(buf_bus.buf_waddr), 64'(0));
        chk("rst_taddr", 64'(trig_addr), 64'(0));
        adc_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
